majority_streak_detector: RTL and testbench

MAJORITY_STREAK_DETECTOR -- requirements
Module: majority_streak_detector

---
 rtl/majority_streak_detector.sv | 140 ++++++++++++++
 tb/tb_majority_streak_detector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/majority_streak_detector.sv
// rtl/majority_streak_detector.sv - per-sample majority hit detector with consecutive-hit streak FSM
//
// Purpose:
//   Each accepted sample has its ones counted. A sample whose count is at
//   least THRESH is a hit. A run of STREAK consecutive accepted hits moves
//   the FSM to DETECTED. Cycles with in_val low are gaps and do not break
//   a streak.
//
// Configuration macro:
//   MAJORITY_STREAK_STICKY_EN - when defined, DETECTED is only left via clr
//   or rst. When undefined, a non-hit sample in DETECTED returns to IDLE.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   in_val  - sample on `in` is accepted this cycle
//   in      - NBITS sample bits
//   clr     - synchronous clear of streak, state and detect (det_cnt kept)
//   count   - registered ones count of the last accepted sample
//   hit     - registered flag, last accepted sample had count >= THRESH
//   streak  - consecutive-hit count, saturating at STREAK
//   state   - FSM state: IDLE=00, TRACK=01, DETECTED=10
//   detect  - high exactly when state is DETECTED
//   det_cnt - number of entries into DETECTED, wraps 255->0
module majority_streak_detector #(
    parameter int NBITS  = 3,
    parameter int THRESH = 2,
    parameter int STREAK = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_val,
    input  logic [NBITS-1:0]               in,
    input  logic                           clr,
    output logic [$clog2(NBITS+1)-1:0]     count,
    output logic                           hit,
    output logic [$clog2(STREAK+1)-1:0]    streak,
    output logic [1:0]                     state,
    output logic                           detect,
    output logic [7:0]                     det_cnt
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int SW = $clog2(STREAK + 1);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [SW-1:0] STREAK_C = SW'(STREAK);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_TRACK    = 2'b01,
        S_DETECTED = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            hit_q, hit_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [7:0]      det_cnt_q, det_cnt_d;

    logic [CW-1:0]   pop;
    logic            sample_hit;
    logic [SW-1:0]   streak_inc;
    logic [SW-1:0]   streak_miss;

    // Combinational popcount over the full sample width.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NBITS; i++) begin
            pop = pop + CW'(in[i]);
        end
    end

    assign sample_hit = (pop >= THRESH_C);
    assign streak_inc = (streak_q == STREAK_C) ? STREAK_C : streak_q + SW'(1);

`ifdef MAJORITY_STREAK_STICKY_EN
    // Once detected, misses cannot pull the streak down; only clr/rst can.
    assign streak_miss = (state_q == S_DETECTED) ? streak_q : '0;
`else
    assign streak_miss = '0;
`endif

    always_comb begin
        count_d   = count_q;
        hit_d     = hit_q;
        streak_d  = streak_q;
        state_d   = state_q;
        det_cnt_d = det_cnt_q;

        // count/hit capture every accepted sample, even alongside clr.
        if (in_val) begin
            count_d = pop;
            hit_d   = sample_hit;
        end

        if (clr) begin
            streak_d = '0;
            state_d  = S_IDLE;
        end else if (in_val) begin
            streak_d = sample_hit ? streak_inc : streak_miss;
            // State follows the post-update streak, so STREAK=1 goes
            // straight from IDLE to DETECTED.
            if (streak_d == '0) begin
                state_d = S_IDLE;
            end else if (streak_d == STREAK_C) begin
                state_d = S_DETECTED;
            end else begin
                state_d = S_TRACK;
            end
        end

        if ((state_d == S_DETECTED) && (state_q != S_DETECTED)) begin
            det_cnt_d = det_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            hit_q     <= 1'b0;
            streak_q  <= '0;
            det_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hit_q     <= hit_d;
            streak_q  <= streak_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    assign count   = count_q;
    assign hit     = hit_q;
    assign streak  = streak_q;
    assign state   = state_q;
    assign detect  = (state_q == S_DETECTED);
    assign det_cnt = det_cnt_q;

endmodule

// File: tb/tb_majority_streak_detector.sv
// tb/tb_majority_streak_detector.sv - self-checking bench for majority_streak_detector
module tb_majority_streak_detector;

    localparam int NBITS  = 3;
    localparam int THRESH = 2;
    localparam int STREAK = 4;
    localparam int CW = $clog2(NBITS + 1);
    localparam int SW = $clog2(STREAK + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_val = 1'b0;
    logic [NBITS-1:0] din = '0;
    logic             clr = 1'b0;
    logic [CW-1:0]    count;
    logic             hit;
    logic [SW-1:0]    streak;
    logic [1:0]       state;
    logic             detect;
    logic [7:0]       det_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    majority_streak_detector #(.NBITS(NBITS), .THRESH(THRESH), .STREAK(STREAK)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_val (in_val),
        .in     (din),
        .clr    (clr),
        .count  (count),
        .hit    (hit),
        .streak (streak),
        .state  (state),
        .detect (detect),
        .det_cnt(det_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       c;
        int         e_count;
        int         e_hit;
        int         e_streak;
        int         e_state;
        int         e_detect;
        int         e_detcnt;
    } vec_t;

    vec_t tbl [19];

    // Reference model: integer streak, state chosen from the streak value.
    int m_count, m_hit, m_streak, m_state, m_detcnt;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input int c, input int h, input int s,
                             input int st, input int d, input int dc);
        check({tag, ".count"},   int'(count),   c);
        check({tag, ".hit"},     int'(hit),     h);
        check({tag, ".streak"},  int'(streak),  s);
        check({tag, ".state"},   int'(state),   st);
        check({tag, ".detect"},  int'(detect),  d);
        check({tag, ".det_cnt"}, int'(det_cnt), dc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] d, input logic c);
        in_val = v;
        din    = d;
        clr    = c;
        tick();
    endtask

    task automatic model_reset();
        m_count = 0; m_hit = 0; m_streak = 0; m_state = 0; m_detcnt = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] d, input logic c);
        int old_state;
        bit h;
        old_state = m_state;
        h = ($countones(d) >= THRESH);
        if (v) begin
            m_count = $countones(d);
            m_hit   = int'(h);
        end
        if (c) begin
            m_streak = 0;
            m_state  = 0;
        end else if (v) begin
            if (h) m_streak = (m_streak + 1 > STREAK) ? STREAK : m_streak + 1;
`ifdef MAJORITY_STREAK_STICKY_EN
            else if (m_state != 2) m_streak = 0;
`else
            else m_streak = 0;
`endif
            m_state = (m_streak == 0) ? 0 : (m_streak == STREAK) ? 2 : 1;
        end
        if (m_state == 2 && old_state != 2) m_detcnt = (m_detcnt + 1) % 256;
    endtask

    initial begin
        // Table: scenarios 1, 2, 3 and 5, applied back to back after reset.
        tbl[0]  = '{1'b1, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 3'b001, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 3'b011, 1'b0, 2, 1, 1, 1, 0, 0};
        tbl[3]  = '{1'b1, 3'b111, 1'b0, 3, 1, 2, 1, 0, 0};
        tbl[4]  = '{1'b0, 3'b000, 1'b1, 3, 1, 0, 0, 0, 0};
        tbl[5]  = '{1'b1, 3'b110, 1'b0, 2, 1, 1, 1, 0, 0};
        tbl[6]  = '{1'b1, 3'b110, 1'b0, 2, 1, 2, 1, 0, 0};
        tbl[7]  = '{1'b1, 3'b110, 1'b0, 2, 1, 3, 1, 0, 0};
        tbl[8]  = '{1'b1, 3'b110, 1'b0, 2, 1, 4, 2, 1, 1};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 2, 1, 4, 2, 1, 1};
        tbl[10] = '{1'b1, 3'b110, 1'b0, 2, 1, 4, 2, 1, 1};
        tbl[11] = '{1'b0, 3'b000, 1'b1, 2, 1, 0, 0, 0, 1};
        tbl[12] = '{1'b1, 3'b110, 1'b0, 2, 1, 1, 1, 0, 1};
        tbl[13] = '{1'b1, 3'b110, 1'b0, 2, 1, 2, 1, 0, 1};
        tbl[14] = '{1'b1, 3'b100, 1'b0, 1, 0, 0, 0, 0, 1};
        tbl[15] = '{1'b1, 3'b110, 1'b0, 2, 1, 1, 1, 0, 1};
        tbl[16] = '{1'b1, 3'b110, 1'b0, 2, 1, 2, 1, 0, 1};
        tbl[17] = '{1'b1, 3'b110, 1'b0, 2, 1, 3, 1, 0, 1};
        tbl[18] = '{1'b1, 3'b111, 1'b1, 3, 1, 0, 0, 0, 1};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].c);
            check_all($sformatf("vec%0d", i), tbl[i].e_count, tbl[i].e_hit, tbl[i].e_streak,
                      tbl[i].e_state, tbl[i].e_detect, tbl[i].e_detcnt);
        end

        // Scenario 4: from IDLE, reach DETECTED then present a miss.
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b110, 1'b0);
        check_all("s4_det", 2, 1, 4, 2, 1, 2);
        drive(1'b1, 3'b000, 1'b0);
`ifdef MAJORITY_STREAK_STICKY_EN
        check_all("s4_miss_sticky", 0, 0, 4, 2, 1, 2);
        drive(1'b1, 3'b001, 1'b0);
        check_all("s4_miss2_sticky", 1, 0, 4, 2, 1, 2);
        drive(1'b0, 3'b000, 1'b1);
        check_all("s4_clr_sticky", 1, 0, 0, 0, 0, 2);
`else
        check_all("s4_miss", 0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b110, 1'b0);
        check_all("s4_redet", 2, 1, 4, 2, 1, 3);
        drive(1'b0, 3'b000, 1'b1);
        check_all("s4_clr", 2, 1, 0, 0, 0, 3);
`endif

        // Scenario 6: asynchronous reset mid-streak, checked before any clk edge.
        drive(1'b1, 3'b011, 1'b0);
        drive(1'b1, 3'b101, 1'b0);
        check("s6_pre.streak", int'(streak), 2);
        in_val = 1'b0;
        #2 rst = 1'b1;
        #1 check_all("s6_async", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        drive(1'b1, 3'b111, 1'b0);
        check_all("s6_after", 3, 1, 1, 1, 0, 0);
        drive(1'b0, 3'b000, 1'b1);
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 4; i++) drive(1'b1, 3'b110, 1'b0);
            if (n == 0) check("s6_det_first", int'(det_cnt), 1);
            if (n == 254) check("s6_det_255", int'(det_cnt), 255);
            if (n == 255) check("s6_det_wrap", int'(det_cnt), 0);
            drive(1'b0, 3'b000, 1'b1);
        end

        // Randomized run against the reference model.
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            logic v, c;
            logic [2:0] d;
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 39) == 0);
            d = 3'($urandom_range(0, 7));
            drive(v, d, c);
            model_step(v, d, c);
            check_all($sformatf("rnd%0d", k), m_count, m_hit, m_streak, m_state,
                      int'(m_state == 2), m_detcnt);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
